// File: rtl/pc_stack_unit_if.sv
// rtl/pc_stack_unit_if.sv - stage/op bundle and PC/RAS status bundle of the PC sequencer
//
// Purpose : groups the sequencer control inputs and PC/RAS outputs.
// Modports:
//   master - control side: drives stage_ex, stage_wb, op_kind, flag_sel, sreg,
//            offset, ind_target; observes program_counter, pc_target,
//            branch_taken, ras_count, ras_overflow, ras_underflow.
//   slave  - the pc_stack_unit side (directions mirrored).
interface pc_stack_unit_if #(
    parameter int I_ADDR_WIDTH = 10,
    parameter int OFFSET_WIDTH = 12,
    parameter int DATA_WIDTH   = 8,
    parameter int RAS_DEPTH    = 8
);
    logic                        stage_ex;
    logic                        stage_wb;
    logic [2:0]                  op_kind;
    logic [2:0]                  flag_sel;
    logic [DATA_WIDTH-1:0]       sreg;
    logic [OFFSET_WIDTH-1:0]     offset;
    logic [I_ADDR_WIDTH-1:0]     ind_target;
    logic [I_ADDR_WIDTH-1:0]     program_counter;
    logic [I_ADDR_WIDTH-1:0]     pc_target;
    logic                        branch_taken;
    logic [$clog2(RAS_DEPTH):0]  ras_count;
    logic                        ras_overflow;
    logic                        ras_underflow;

    modport master (
        output stage_ex, stage_wb, op_kind, flag_sel, sreg, offset, ind_target,
        input  program_counter, pc_target, branch_taken, ras_count,
               ras_overflow, ras_underflow
    );

    modport slave (
        input  stage_ex, stage_wb, op_kind, flag_sel, sreg, offset, ind_target,
        output program_counter, pc_target, branch_taken, ras_count,
               ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - program-counter sequencer with hardware return-address stack
//
// Purpose : computes the next PC in EX (relative branches, RJMP, RCALL/RET,
//           optionally IJMP/ICALL), holds it in pc_target and loads it into
//           program_counter in WB. Return addresses live in a circular RAS.
// Ports   : clk, reset (async, active-high), bus (pc_stack_unit_if.slave).
// Macro   : PC_INDIRECT_EN - enables IJMP/ICALL; otherwise op 6/7 act as NONE.
module pc_stack_unit #(
    parameter int I_ADDR_WIDTH    = 10,
    parameter int OFFSET_WIDTH    = 12,
    parameter int BR_OFFSET_WIDTH = 7,
    parameter int RAS_DEPTH       = 8,
    parameter int DATA_WIDTH      = 8
) (
    input  logic              clk,
    input  logic              reset,
    pc_stack_unit_if.slave    bus
);
    localparam int AW = ((I_ADDR_WIDTH > OFFSET_WIDTH) ? I_ADDR_WIDTH : OFFSET_WIDTH) + 1;
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(RAS_DEPTH);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_BRBS  = 3'd1,
        OP_BRBC  = 3'd2,
        OP_RJMP  = 3'd3,
        OP_RCALL = 3'd4,
        OP_RET   = 3'd5,
        OP_IJMP  = 3'd6,
        OP_ICALL = 3'd7
    } op_t;

    logic [I_ADDR_WIDTH-1:0] r_pc;
    logic [I_ADDR_WIDTH-1:0] r_target;
    logic                    r_taken;
    logic [CW-1:0]           r_count;
    logic [PW-1:0]           r_ptr;      // next slot to write; newest entry is r_ptr-1
    logic                    r_ovf;
    logic                    r_unf;
    logic [I_ADDR_WIDTH-1:0] r_ras [RAS_DEPTH];

    logic [I_ADDR_WIDTH-1:0] w_pc_plus1;
    logic [AW-1:0]           w_rel_sum;
    logic [AW-1:0]           w_br_sum;
    logic [I_ADDR_WIDTH-1:0] w_ras_top;
    logic                    w_flag;
    logic [I_ADDR_WIDTH-1:0] w_target;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_force_taken;
    op_t                     w_op;

    assign w_op       = op_t'(bus.op_kind);
    assign w_pc_plus1 = r_pc + 1'b1;
    assign w_flag     = bus.sreg[bus.flag_sel];
    assign w_ras_top  = r_ras[r_ptr - 1'b1];

    // Wide add then truncate: the wrap-around is the intended modulo behaviour.
    assign w_rel_sum = {{(AW-I_ADDR_WIDTH){1'b0}}, w_pc_plus1}
                     + {{(AW-OFFSET_WIDTH){bus.offset[OFFSET_WIDTH-1]}}, bus.offset};
    assign w_br_sum  = {{(AW-I_ADDR_WIDTH){1'b0}}, w_pc_plus1}
                     + {{(AW-BR_OFFSET_WIDTH){bus.offset[BR_OFFSET_WIDTH-1]}},
                        bus.offset[BR_OFFSET_WIDTH-1:0]};

`ifndef PC_INDIRECT_EN
    logic w_unused_ind;
    assign w_unused_ind = ^bus.ind_target;
`endif

    always_comb begin
        w_target      = w_pc_plus1;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_force_taken = 1'b0;
        case (w_op)
            OP_BRBS: if (w_flag)  w_target = w_br_sum[I_ADDR_WIDTH-1:0];
            OP_BRBC: if (!w_flag) w_target = w_br_sum[I_ADDR_WIDTH-1:0];
            OP_RJMP: w_target = w_rel_sum[I_ADDR_WIDTH-1:0];
            OP_RCALL: begin
                w_push        = 1'b1;
                w_force_taken = 1'b1;
                w_target      = w_rel_sum[I_ADDR_WIDTH-1:0];
            end
            OP_RET: begin
                w_pop         = 1'b1;
                w_force_taken = 1'b1;
                // Empty stack: fall through to PC+1, flag raised below.
                if (r_count != '0) w_target = w_ras_top;
            end
`ifdef PC_INDIRECT_EN
            OP_IJMP: w_target = bus.ind_target;
            OP_ICALL: begin
                w_push   = 1'b1;
                w_target = bus.ind_target;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= '0;
            r_target <= '0;
            r_taken  <= 1'b0;
            r_count  <= '0;
            r_ptr    <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else if (bus.stage_ex) begin
            // EX wins over WB when both are asserted.
            r_target <= w_target;
            r_taken  <= w_force_taken || (w_target != w_pc_plus1);
            if (w_push) begin
                r_ptr <= r_ptr + 1'b1;
                if (r_count == C_FULL) r_ovf   <= 1'b1;
                else                   r_count <= r_count + 1'b1;
            end else if (w_pop) begin
                if (r_count == '0) begin
                    r_unf <= 1'b1;
                end else begin
                    r_ptr   <= r_ptr - 1'b1;
                    r_count <= r_count - 1'b1;
                end
            end
        end else begin
            r_taken <= 1'b0;
            if (bus.stage_wb) r_pc <= r_target;
        end
    end

    // Entry storage needs no reset; the pointer/count define validity.
    // When full, r_ptr addresses the oldest entry, so a push overwrites it.
    always_ff @(posedge clk) begin
        if (!reset && bus.stage_ex && w_push) r_ras[r_ptr] <= w_pc_plus1;
    end

    assign bus.program_counter = r_pc;
    assign bus.pc_target       = r_target;
    assign bus.branch_taken    = r_taken;
    assign bus.ras_count       = r_count;
    assign bus.ras_overflow    = r_ovf;
    assign bus.ras_underflow   = r_unf;
endmodule
